// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single write port of the CPU register bank.
// GNT is combinational; WE/WADDR/WDATA are registered one cycle after acceptance.
// An optional lock gives one requester up to MAX_LOCK back-to-back writes.
module reg_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic                      CLK,
    input  logic                      CLEAR,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ-1:0]          LOCK,
    input  logic [N_REQ*ADDR_W-1:0]   ADDR,
    input  logic [N_REQ*DATA_W-1:0]   DATA,
    output logic [N_REQ-1:0]          GNT,
    output logic                      WE,
    output logic [ADDR_W-1:0]         WADDR,
    output logic [DATA_W-1:0]         WDATA,
    output logic                      BUSY
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic [PW-1:0]     sel;
    logic [N_REQ-1:0]  gnt;
    logic [PW:0]       scan;

    // Next pointer value after index p, wrapping N_REQ-1 back to 0.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] p);
        if (p == PW'(N_REQ - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Grant selection: owner only while locked, otherwise round-robin scan from ptr.
    always_comb begin
        gnt    = '0;
        sel    = '0;
        accept = 1'b0;
        scan   = '0;
        if (state_q == LOCKED) begin
            if (REQ[owner_q]) begin
                sel    = owner_q;
                accept = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan = {1'b0, ptr_q} + (PW + 1)'(k);
                if (scan >= (PW + 1)'(N_REQ)) begin
                    scan = scan - (PW + 1)'(N_REQ);
                end
                if (!accept && REQ[scan[PW-1:0]]) begin
                    sel    = scan[PW-1:0];
                    accept = 1'b1;
                end
            end
        end
        if (accept) begin
            gnt[sel] = 1'b1;
        end
    end

    // Lock FSM, round-robin pointer and consecutive-grant counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // With MAX_LOCK of 1 the first locked write already exhausts the
                    // budget, so it is treated as an ordinary unlocked transfer.
                    if (LOCK[sel] && (MAX_LOCK > 1)) begin
                        state_d = LOCKED;
                        owner_d = sel;
                        cnt_d   = CW'(1);
                    end else begin
                        ptr_d = next_idx(sel);
                    end
                end
            end
            LOCKED: begin
                if (accept && (int'(cnt_q) < MAX_LOCK)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!REQ[owner_q] || !LOCK[owner_q] ||
                    (accept && (int'(cnt_q) + 1 >= MAX_LOCK))) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port next values: capture the accepted requester's address and data.
    always_comb begin
        we_d    = accept;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept) begin
            waddr_d = ADDR[sel*ADDR_W +: ADDR_W];
            wdata_d = DATA[sel*DATA_W +: DATA_W];
        end
    end

    // State and write-port registers with asynchronous clear.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign GNT   = gnt;
    assign WE    = we_q;
    assign WADDR = waddr_q;
    assign WDATA = wdata_q;
    assign BUSY  = (state_q == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a cycle-level reference model predicts
// grants and queues expected writes; a monitor checks each WE pulse against the queue.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int ML = 8;

    logic              CLK = 1'b0;
    logic              CLEAR;
    logic [N-1:0]      REQ;
    logic [N-1:0]      LOCK;
    logic [N*AW-1:0]   ADDR;
    logic [N*DW-1:0]   DATA;
    logic [N-1:0]      GNT;
    logic              WE;
    logic [AW-1:0]     WADDR;
    logic [DW-1:0]     WDATA;
    logic              BUSY;

    reg_write_arbiter #(
        .N_REQ    (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_LOCK (ML)
    ) dut (
        .CLK   (CLK),
        .CLEAR (CLEAR),
        .REQ   (REQ),
        .LOCK  (LOCK),
        .ADDR  (ADDR),
        .DATA  (DATA),
        .GNT   (GNT),
        .WE    (WE),
        .WADDR (WADDR),
        .WDATA (WDATA),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    logic [AW-1:0] p_addr[N];
    logic [DW-1:0] p_data[N];

    // Reference model state: plain integers, not the RTL encoding.
    int            m_ptr;
    bit            m_locked;
    int            m_owner;
    int            m_cnt;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        return 1'(v >> i);
    endfunction

    function automatic int model_grant(input logic [N-1:0] req);
        if (m_locked) begin
            return bitof(req, m_owner) ? m_owner : -1;
        end
        for (int k = 0; k < N; k++) begin
            if (bitof(req, (m_ptr + k) % N)) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lock, input int g);
        if (!m_locked) begin
            if (g >= 0) begin
                if (bitof(lock, g) && ML > 1) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_cnt    = 1;
                end else begin
                    m_ptr = (g + 1) % N;
                end
            end
        end else begin
            if (g >= 0) m_cnt++;
            if (!bitof(req, m_owner) || !bitof(lock, m_owner) || m_cnt >= ML) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic pack_inputs();
        ADDR = '0;
        DATA = '0;
        for (int i = 0; i < N; i++) begin
            ADDR = ADDR | ((N*AW)'(p_addr[i]) << (i * AW));
            DATA = DATA | ((N*DW)'(p_data[i]) << (i * DW));
        end
    endtask

    // One clock cycle of traffic, entered and left at a falling edge.
    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] lock, output int g);
        logic [N-1:0] eg;
        REQ  = req;
        LOCK = lock;
        pack_inputs();
        #1;
        g  = model_grant(req);
        eg = (g >= 0) ? (N'(1) << g) : '0;
        chk("GNT", 64'(GNT), 64'(eg));
        chk("BUSY", 64'(BUSY), 64'(m_locked));
        if (g >= 0) sb.push_back('{cyc: cyc + 1, a: p_addr[g], d: p_data[g]});
        @(posedge CLK);
        model_step(req, lock, g);
        @(negedge CLK);
    endtask

    // Hold CLEAR across one rising edge; outputs must drop immediately.
    task automatic clear_cycle();
        int g;
        CLEAR = 1'b1;
        #1;
        model_reset();
        chk("CLR_WE", 64'(WE), 64'(0));
        chk("CLR_BUSY", 64'(BUSY), 64'(0));
        chk("CLR_WADDR", 64'(WADDR), 64'(0));
        chk("CLR_WDATA", 64'(WDATA), 64'(0));
        g = model_grant(REQ);
        chk("CLR_GNT", 64'(GNT), 64'((g >= 0) ? (N'(1) << g) : '0));
        @(posedge CLK);
        @(negedge CLK);
        CLEAR = 1'b0;
    endtask

    // Monitor: every WE pulse must match the oldest queued write, in the right cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (WE === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("WE_spurious", 64'(WE), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("WE_cycle", 64'(cyc), 64'(e.cyc));
                    chk("WADDR", 64'(WADDR), 64'(e.a));
                    chk("WDATA", 64'(WDATA), 64'(e.d));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("WE_missing", 64'(WE), 64'(1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int gl[$];
        bit pend[N];
        bit lockw[N];
        logic [N-1:0] rq, lk;

        CLEAR = 1'b1;
        REQ   = '0;
        LOCK  = '0;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = '0;
            p_data[i] = '0;
            pend[i]   = 1'b0;
            lockw[i]  = 1'b0;
        end
        pack_inputs();
        model_reset();
        repeat (2) @(negedge CLK);
        chk("RST_WE", 64'(WE), 64'(0));
        chk("RST_WADDR", 64'(WADDR), 64'(0));
        chk("RST_WDATA", 64'(WDATA), 64'(0));
        chk("RST_BUSY", 64'(BUSY), 64'(0));
        CLEAR = 1'b0;

        // Single write from requester 2, then requests drop.
        p_addr[2] = 3'd5;
        p_data[2] = 8'hA5;
        cycle(4'b0100, 4'b0000, g);
        chk("T1_WE_high", 64'(WE), 64'(1));
        cycle(4'b0000, 4'b0000, g);
        chk("T1_WE_drop", 64'(WE), 64'(0));

        // Plain round robin from ptr=0 with everyone requesting.
        clear_cycle();
        for (int i = 0; i < N; i++) begin
            p_addr[i] = AW'(i + 1);
            p_data[i] = DW'(8'h10 * (i + 1));
        end
        gl.delete();
        repeat (6) begin
            cycle(4'b1111, 4'b0000, g);
            gl.push_back(g);
        end
        chk("T2_order", 64'({gl[0][3:0], gl[1][3:0], gl[2][3:0], gl[3][3:0], gl[4][3:0], gl[5][3:0]}),
            64'(24'h012301));

        // Requester 1 locks for three writes, then releases with a final write.
        clear_cycle();
        cycle(4'b0001, 4'b0000, g);
        repeat (3) cycle(4'b1111, 4'b0010, g);
        cycle(4'b1111, 4'b0000, g);
        cycle(4'b1111, 4'b0000, g);
        chk("T3_after_lock", 64'(g), 64'(2));

        // Requester 0 holds lock past MAX_LOCK while requester 3 waits.
        clear_cycle();
        repeat (12) cycle(4'b1001, 4'b0001, g);

        // Clear in the middle of a lock owned by requester 2.
        clear_cycle();
        repeat (3) cycle(4'b0100, 4'b0100, g);
        clear_cycle();
        cycle(4'b1111, 4'b0000, g);
        chk("T5_first", 64'(g), 64'(0));

        // Idle gap after a grant to requester 1.
        clear_cycle();
        cycle(4'b0010, 4'b0000, g);
        repeat (5) begin
            cycle(4'b0000, 4'b0000, g);
            chk("T6_idle_WE", 64'(WE), 64'(0));
        end
        cycle(4'b0011, 4'b0000, g);

        // Randomized traffic with sticky lock wishes and occasional clears.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i]   = 1'b1;
                    p_addr[i] = AW'($urandom);
                    p_data[i] = DW'($urandom);
                end
                if ($urandom_range(0, 9) == 0) lockw[i] = ~lockw[i];
            end
            rq = '0;
            lk = '0;
            for (int i = 0; i < N; i++) begin
                rq = rq | (N'(pend[i]) << i);
                lk = lk | (N'(pend[i] & lockw[i]) << i);
            end
            if ($urandom_range(0, 149) == 0) begin
                REQ  = rq;
                LOCK = lk;
                pack_inputs();
                clear_cycle();
            end else begin
                cycle(rq, lk, g);
                if (g >= 0) pend[g] = 1'b0;
            end
        end

        repeat (3) cycle(4'b0000, 4'b0000, g);
        chk("SB_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
